// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, pointer type and clog2 helper for the FIFO controller
package fifo_pkg;

  localparam int DEF_SIZE_ADDR  = 4;
  localparam int DEF_SIZE_DEPTH = 16;

  typedef logic [DEF_SIZE_ADDR:0] ptr_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// rtl/fifo_ptr_cnt.sv - wrapping binary pointer with increment enable and flush
module fifo_ptr_cnt
  import fifo_pkg::*;
#(
  parameter int W = DEF_SIZE_ADDR + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         flush,
  output logic [W-1:0] ptr
);

  // MSB acts as the wrap bit, so the natural modulo-2^W rollover is intended
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (flush) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/fifo_ctrl_sync.sv
// rtl/fifo_ctrl_sync.sv - single-clock FIFO controller; optional flush via FIFO_CTRL_FLUSH_EN
module fifo_ctrl_sync
  import fifo_pkg::*;
#(
  parameter int SIZE_ADDR     = DEF_SIZE_ADDR,
  parameter int SIZE_DEPTH    = DEF_SIZE_DEPTH,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
`ifdef FIFO_CTRL_FLUSH_EN
  input  logic                 i_flush,
`endif
  input  logic                 i_wr_req,
  input  logic                 i_rd_req,
  output logic                 o_mem_wr_en,
  output logic                 o_mem_rd_en,
  output logic [SIZE_ADDR-1:0] o_mem_addr_wr,
  output logic [SIZE_ADDR-1:0] o_mem_addr_rd,
  output logic                 o_rd_valid,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_almost_full,
  output logic                 o_almost_empty,
  output logic [SIZE_ADDR:0]   o_count,
  output logic                 o_overflow,
  output logic                 o_underflow
);

  if (SIZE_DEPTH != (2 ** SIZE_ADDR) || clog2(SIZE_DEPTH) != SIZE_ADDR) begin : g_bad_depth
    $error("fifo_ctrl_sync: SIZE_DEPTH must equal 2**SIZE_ADDR");
  end

  localparam logic [SIZE_ADDR:0] AFULL_T  = (SIZE_ADDR + 1)'(AFULL_THRESH);
  localparam logic [SIZE_ADDR:0] AEMPTY_T = (SIZE_ADDR + 1)'(AEMPTY_THRESH);

  logic               flush;
  logic [SIZE_ADDR:0] wr_ptr;
  logic [SIZE_ADDR:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

`ifdef FIFO_CTRL_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Status derives only from registered pointers, never from this cycle's requests
  assign o_count        = wr_ptr - rd_ptr;
  assign o_empty        = (wr_ptr == rd_ptr);
  assign o_full         = (wr_ptr[SIZE_ADDR-1:0] == rd_ptr[SIZE_ADDR-1:0]) &&
                          (wr_ptr[SIZE_ADDR] != rd_ptr[SIZE_ADDR]);
  assign o_almost_full  = (o_count >= AFULL_T);
  assign o_almost_empty = (o_count <= AEMPTY_T);

  // A pop frees the slot the push lands in, so push+pop is legal when full
  assign pop_ok  = i_rd_req & ~o_empty & ~flush;
  assign push_ok = i_wr_req & (~o_full | pop_ok) & ~flush;

  assign o_mem_wr_en   = push_ok;
  assign o_mem_rd_en   = pop_ok;
  assign o_mem_addr_wr = wr_ptr[SIZE_ADDR-1:0];
  assign o_mem_addr_rd = rd_ptr[SIZE_ADDR-1:0];

  fifo_ptr_cnt #(.W(SIZE_ADDR + 1)) u_wr_ptr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (push_ok),
    .flush (flush),
    .ptr   (wr_ptr)
  );

  fifo_ptr_cnt #(.W(SIZE_ADDR + 1)) u_rd_ptr (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (pop_ok),
    .flush (flush),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_valid  <= 1'b0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_rd_valid <= pop_ok;
      if (i_wr_req && !push_ok && !flush) o_overflow <= 1'b1;
      if (i_rd_req && o_empty && !flush)  o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// tb/tb_fifo_ctrl_sync.sv - scoreboard bench for fifo_ctrl_sync with a behavioural memory
module tb_fifo_ctrl_sync;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_flush = 1'b0;
  logic       i_wr_req = 1'b0;
  logic       i_rd_req = 1'b0;
  logic       o_mem_wr_en, o_mem_rd_en, o_rd_valid;
  logic [3:0] o_mem_addr_wr, o_mem_addr_rd;
  logic       o_full, o_empty, o_almost_full, o_almost_empty;
  logic [4:0] o_count;
  logic       o_overflow, o_underflow;

  logic [7:0] mem [16];
  logic [7:0] rdata;
  logic [7:0] wdata = 8'h00;

  int tests = 0;
  int fails = 0;

  int         mcount;
  logic [3:0] mwa, mra;
  bit         movf, mudf, mrv, exp_push, exp_pop;
  logic [7:0] exp_rdata;
  logic [7:0] sb [$];

  always #5 i_clk = ~i_clk;

  fifo_ctrl_sync dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
`ifdef FIFO_CTRL_FLUSH_EN
    .i_flush        (i_flush),
`endif
    .i_wr_req       (i_wr_req),
    .i_rd_req       (i_rd_req),
    .o_mem_wr_en    (o_mem_wr_en),
    .o_mem_rd_en    (o_mem_rd_en),
    .o_mem_addr_wr  (o_mem_addr_wr),
    .o_mem_addr_rd  (o_mem_addr_rd),
    .o_rd_valid     (o_rd_valid),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_count        (o_count),
    .o_overflow     (o_overflow),
    .o_underflow    (o_underflow)
  );

  always @(posedge i_clk) begin
    if (o_mem_wr_en) mem[o_mem_addr_wr] <= wdata;
    if (o_mem_rd_en) rdata <= mem[o_mem_addr_rd];
  end

  task automatic model_clear();
    mcount = 0; mwa = '0; mra = '0; mrv = 0;
    exp_push = 0; exp_pop = 0;
    sb.delete();
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0; i_wr_req = 1'b0; i_rd_req = 1'b0; i_flush = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    model_clear();
    movf = 0; mudf = 0;
  endtask

  task automatic drive(input bit wr, input bit rd, input logic [7:0] d);
    i_wr_req = wr; i_rd_req = rd; wdata = d;
    exp_pop  = rd && (mcount > 0);
    exp_push = wr && ((mcount < 16) || exp_pop);
    if (exp_pop)  exp_rdata = sb.pop_front();
    if (exp_push) sb.push_back(d);
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (i_wr_req && !exp_push) movf = 1;
    if (i_rd_req && mcount == 0) mudf = 1;
    mcount = mcount + int'(exp_push) - int'(exp_pop);
    if (exp_push) mwa = mwa + 4'd1;
    if (exp_pop)  mra = mra + 4'd1;
    mrv = exp_pop;
    #1;
    i_wr_req = 1'b0; i_rd_req = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({o_empty, o_full, o_almost_empty, o_almost_full} !== 4'b1010) begin
      fails++; $display("FAIL reset_flags: got %b expected 1010", {o_empty, o_full, o_almost_empty, o_almost_full});
    end
    tests++;
    if (o_count !== 5'd0) begin
      fails++; $display("FAIL reset_count: got %0d expected 0", o_count);
    end
    tests++;
    if ({o_overflow, o_underflow, o_rd_valid, o_mem_wr_en, o_mem_rd_en} !== 5'b0) begin
      fails++; $display("FAIL reset_misc: got %b expected 00000", {o_overflow, o_underflow, o_rd_valid, o_mem_wr_en, o_mem_rd_en});
    end
  endtask

  task automatic test_single();
    drive(1, 0, 8'hA5);
    tests++;
    if (o_mem_wr_en !== 1'b1 || o_mem_addr_wr !== 4'd0) begin
      fails++; $display("FAIL single_write: got en=%b addr=%0d expected en=1 addr=0", o_mem_wr_en, o_mem_addr_wr);
    end
    tick();
    drive(0, 1, 8'h00);
    tests++;
    if (o_mem_rd_en !== 1'b1 || o_mem_addr_rd !== 4'd0) begin
      fails++; $display("FAIL single_read: got en=%b addr=%0d expected en=1 addr=0", o_mem_rd_en, o_mem_addr_rd);
    end
    tick();
    tests++;
    if (o_rd_valid !== 1'b1 || rdata !== exp_rdata) begin
      fails++; $display("FAIL single_data: got valid=%b data=%h expected valid=1 data=%h", o_rd_valid, rdata, exp_rdata);
    end
  endtask

  task automatic test_fill_wrap();
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(i * 7 + 3));
      tests++;
      if (o_mem_wr_en !== 1'b1 || o_mem_addr_wr !== mwa) begin
        fails++; $display("FAIL fill_write: got en=%b addr=%0d expected en=1 addr=%0d", o_mem_wr_en, o_mem_addr_wr, mwa);
      end
      tick();
      tests++;
      if (o_count !== mcount[4:0] || o_almost_full !== (mcount >= 14) ||
          o_full !== (mcount == 16) || o_almost_empty !== (mcount <= 2)) begin
        fails++; $display("FAIL fill_status: got cnt=%0d af=%b f=%b ae=%b expected cnt=%0d af=%b f=%b ae=%b",
                          o_count, o_almost_full, o_full, o_almost_empty,
                          mcount, mcount >= 14, mcount == 16, mcount <= 2);
      end
    end
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 8'(8'h40 + i));
      tests++;
      if (o_mem_wr_en !== 1'b1 || o_mem_rd_en !== 1'b1 || o_mem_addr_rd !== mra || o_mem_addr_wr !== mwa) begin
        fails++; $display("FAIL wrap_enables: got wr=%b rd=%b aw=%0d ar=%0d expected 1 1 %0d %0d",
                          o_mem_wr_en, o_mem_rd_en, o_mem_addr_wr, o_mem_addr_rd, mwa, mra);
      end
      tick();
      tests++;
      if (o_count !== 5'd16 || o_overflow !== 1'b0 || o_rd_valid !== 1'b1 || rdata !== exp_rdata) begin
        fails++; $display("FAIL wrap_data: got cnt=%0d ovf=%b rv=%b data=%h expected cnt=16 ovf=0 rv=1 data=%h",
                          o_count, o_overflow, o_rd_valid, rdata, exp_rdata);
      end
    end
    drive(1, 0, 8'hFF);
    tests++;
    if (o_mem_wr_en !== 1'b0) begin
      fails++; $display("FAIL overflow_we: got %b expected 0", o_mem_wr_en);
    end
    tick();
    tests++;
    if (o_overflow !== movf || o_count !== 5'd16 || o_full !== 1'b1) begin
      fails++; $display("FAIL overflow_flag: got ovf=%b cnt=%0d f=%b expected ovf=%b cnt=16 f=1", o_overflow, o_count, o_full, movf);
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    drive(0, 1, 8'h00);
    tests++;
    if (o_mem_rd_en !== 1'b0) begin
      fails++; $display("FAIL underflow_re: got %b expected 0", o_mem_rd_en);
    end
    tick();
    tests++;
    if (o_underflow !== mudf || o_underflow !== 1'b1 || o_rd_valid !== 1'b0) begin
      fails++; $display("FAIL underflow_flag: got udf=%b rv=%b expected udf=1 rv=0", o_underflow, o_rd_valid);
    end
    drive(1, 1, 8'h3C);
    tests++;
    if (o_mem_wr_en !== 1'b1 || o_mem_rd_en !== 1'b0) begin
      fails++; $display("FAIL empty_pushpop: got wr=%b rd=%b expected wr=1 rd=0", o_mem_wr_en, o_mem_rd_en);
    end
    tick();
    tests++;
    if (o_count !== 5'd1 || o_rd_valid !== 1'b0 || o_overflow !== 1'b0) begin
      fails++; $display("FAIL empty_pushpop_cnt: got cnt=%0d rv=%b ovf=%b expected cnt=1 rv=0 ovf=0", o_count, o_rd_valid, o_overflow);
    end
    drive(0, 1, 8'h00);
    tick();
    tests++;
    if (o_rd_valid !== 1'b1 || rdata !== exp_rdata) begin
      fails++; $display("FAIL empty_pushpop_data: got rv=%b data=%h expected rv=1 data=%h", o_rd_valid, rdata, exp_rdata);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 8'(8'h90 + i));
      tick();
    end
    drive(0, 1, 8'h00);
    tick();
    tests++;
    if (o_count !== 5'd7 || o_rd_valid !== 1'b1) begin
      fails++; $display("FAIL pre_reset: got cnt=%0d rv=%b expected cnt=7 rv=1", o_count, o_rd_valid);
    end
    #2;
    i_rst_n = 1'b0;
    #1;
    tests++;
    if (o_count !== 5'd0 || o_empty !== 1'b1 || o_rd_valid !== 1'b0 ||
        o_almost_empty !== 1'b1 || o_full !== 1'b0 || o_almost_full !== 1'b0) begin
      fails++; $display("FAIL async_reset: got cnt=%0d e=%b rv=%b ae=%b f=%b af=%b expected 0 1 0 1 0 0",
                        o_count, o_empty, o_rd_valid, o_almost_empty, o_full, o_almost_full);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_clear();
    movf = 0; mudf = 0;
    @(posedge i_clk);
    #1;
    tests++;
    if (o_empty !== 1'b1 || o_underflow !== 1'b0) begin
      fails++; $display("FAIL post_reset: got e=%b udf=%b expected e=1 udf=0", o_empty, o_underflow);
    end
  endtask

`ifdef FIFO_CTRL_FLUSH_EN
  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 8'(i));
      tick();
    end
    i_flush = 1'b1; i_wr_req = 1'b1;
    #1;
    tests++;
    if (o_mem_wr_en !== 1'b0 || o_mem_rd_en !== 1'b0) begin
      fails++; $display("FAIL flush_enables: got wr=%b rd=%b expected 0 0", o_mem_wr_en, o_mem_rd_en);
    end
    @(posedge i_clk);
    #1;
    i_flush = 1'b0; i_wr_req = 1'b0;
    model_clear();
    tests++;
    if (o_count !== 5'd0 || o_empty !== 1'b1 || o_rd_valid !== 1'b0 || o_overflow !== movf) begin
      fails++; $display("FAIL flush_state: got cnt=%0d e=%b rv=%b ovf=%b expected 0 1 0 %b", o_count, o_empty, o_rd_valid, o_overflow, movf);
    end
  endtask
`endif

  initial begin
    apply_reset();
    test_reset();
    test_single();
    test_fill_wrap();
    test_underflow();
    test_async_reset();
`ifdef FIFO_CTRL_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
